// File: rtl/i2c_target_regs.sv
// I2C target exposing a DEPTH x 8 register file: pointer write, data write with
// auto-increment, and reads from the pointer. Every committed write is echoed on wr_stb.
module i2c_target_regs #(
  parameter logic [6:0] ADDR  = 7'h3C,
  parameter int         DEPTH = 16,
  localparam int        AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  output logic          wr_stb,
  output logic [AW-1:0] wr_reg,
  output logic [7:0]    wr_data,
  output logic          busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_IGNORE
  } state_t;

  logic          r_scl_s1, r_scl_s2, r_scl_h;
  logic          r_sda_s1, r_sda_s2, r_sda_h;
  state_t        r_state;
  logic [3:0]    r_bitcnt;
  logic [6:0]    r_shift;
  logic [7:0]    r_tx;
  logic          r_rw;
  logic          r_ack_on;
  logic [AW-1:0] r_ptr;
  logic [7:0]    r_regs [DEPTH];
  logic          r_sda_oe, r_wr_stb, r_busy;
  logic [AW-1:0] r_wr_reg;
  logic [7:0]    r_wr_data;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_byte, w_rd_byte;

  // Sync flops idle high so leaving reset never fakes a bus condition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_h <= 1'b1;
      r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_h <= 1'b1;
    end else begin
      r_scl_s1 <= scl_in; r_scl_s2 <= r_scl_s1; r_scl_h <= r_scl_s2;
      r_sda_s1 <= sda_in; r_sda_s2 <= r_sda_s1; r_sda_h <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_h;
  assign w_scl_fall = ~r_scl_s2 & r_scl_h;
  assign w_start    = r_scl_s2 & r_scl_h & r_sda_h & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_h & ~r_sda_h & r_sda_s2;
  assign w_byte     = {r_shift, r_sda_s2};
  assign w_rd_byte  = r_regs[r_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_tx      <= '0;
      r_rw      <= 1'b0;
      r_ack_on  <= 1'b0;
      r_ptr     <= '0;
      r_sda_oe  <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= 8'h00;
    end else begin
      r_wr_stb <= 1'b0;
      // Bus conditions win over any bit event seen in the same cycle.
      if (w_stop) begin
        r_state  <= S_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
        r_ack_on <= 1'b0;
      end else if (w_start) begin
        r_state  <= S_ADDR;
        r_bitcnt <= '0;
        r_sda_oe <= 1'b0;
        r_ack_on <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: if (w_scl_rise) begin
            r_shift  <= w_byte[6:0];
            r_bitcnt <= r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) begin
              r_bitcnt <= '0;
              if (w_byte[7:1] == ADDR) begin
                r_state <= S_ADDR_ACK;
                r_rw    <= w_byte[0];
                r_busy  <= 1'b1;
              end else begin
                r_state <= S_IGNORE;
              end
            end
          end
          // First fall pulls SDA for the 9th clock, second fall ends it.
          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (w_scl_fall) begin
            if (!r_ack_on) begin
              r_sda_oe <= 1'b1;
              r_ack_on <= 1'b1;
            end else begin
              r_ack_on <= 1'b0;
              r_bitcnt <= '0;
              if (r_state == S_ADDR_ACK && r_rw) begin
                r_state  <= S_RDATA;
                r_sda_oe <= ~w_rd_byte[7];
                r_tx     <= {w_rd_byte[6:0], 1'b0};
                r_bitcnt <= 4'd1;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= (r_state == S_ADDR_ACK) ? S_PTR : S_WDATA;
              end
            end
          end
          S_PTR: if (w_scl_rise) begin
            r_shift  <= w_byte[6:0];
            r_bitcnt <= r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) begin
              r_bitcnt <= '0;
              r_ptr    <= w_byte[AW-1:0];
              r_state  <= S_PTR_ACK;
            end
          end
          S_WDATA: if (w_scl_rise) begin
            r_shift  <= w_byte[6:0];
            r_bitcnt <= r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) begin
              r_bitcnt      <= '0;
              r_regs[r_ptr] <= w_byte;
              r_wr_stb      <= 1'b1;
              r_wr_reg      <= r_ptr;
              r_wr_data     <= w_byte;
              r_ptr         <= r_ptr + 1'b1;
              r_state       <= S_WDATA_ACK;
            end
          end
          // r_bitcnt counts bits already placed; the fall after the 8th releases SDA.
          S_RDATA: if (w_scl_fall) begin
            if (r_bitcnt == 4'd8) begin
              r_sda_oe <= 1'b0;
              r_bitcnt <= '0;
              r_state  <= S_RACK;
            end else begin
              r_sda_oe <= ~r_tx[7];
              r_tx     <= {r_tx[6:0], 1'b0};
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end
          S_RACK: begin
            if (!r_ack_on && w_scl_rise) begin
              r_ptr <= r_ptr + 1'b1;
              if (!r_sda_s2) r_ack_on <= 1'b1;
              else           r_state  <= S_IGNORE;
            end else if (r_ack_on && w_scl_fall) begin
              r_ack_on <= 1'b0;
              r_state  <= S_RDATA;
              r_sda_oe <= ~w_rd_byte[7];
              r_tx     <= {w_rd_byte[6:0], 1'b0};
              r_bitcnt <= 4'd1;
            end
          end
          S_IDLE, S_IGNORE: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign sda_oe  = r_sda_oe;
  assign wr_stb  = r_wr_stb;
  assign wr_reg  = r_wr_reg;
  assign wr_data = r_wr_data;
  assign busy    = r_busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: bit-banged I2C controller against i2c_target_regs, table-driven
// writes followed by hand-written read, abort and reset sequences.
module tb_i2c_target_regs;
  localparam int Q = 6;
  localparam int H = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_oe, wr_stb, busy;
  logic [3:0] wr_reg;
  logic [7:0] wr_data;
  logic       sda_bus;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;
  assign sda_bus = m_sda & ~sda_oe;

  i2c_target_regs #(.ADDR(7'h3C), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .scl_in(m_scl), .sda_in(sda_bus),
    .sda_oe(sda_oe), .wr_stb(wr_stb), .wr_reg(wr_reg), .wr_data(wr_data), .busy(busy)
  );

  logic [11:0] stbq[$];
  logic        oe_seen = 1'b0, busy_seen = 1'b0, prev_stb = 1'b0;

  always @(negedge clk) begin
    if (wr_stb) stbq.push_back({wr_reg, wr_data});
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (prev_stb) begin
      checks++;
      if (wr_stb) begin
        errors++;
        $display("FAIL stb_width: wr_stb still 1 on second cycle, required 0");
      end
    end
    prev_stb = wr_stb;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start();
    m_sda = 1'b1; clk_n(Q);
    m_scl = 1'b1; clk_n(Q);
    m_sda = 1'b0; clk_n(Q);
    m_scl = 1'b0; clk_n(Q);
  endtask

  task automatic m_stop();
    m_sda = 1'b0; clk_n(Q);
    m_scl = 1'b1; clk_n(Q);
    m_sda = 1'b1; clk_n(4);
    chk("busy_after_stop", 32'(busy), 32'd0);
    chk("oe_after_stop", 32'(sda_oe), 32'd0);
    clk_n(Q);
  endtask

  task automatic m_wbit(input logic b);
    m_sda = b;    clk_n(Q);
    m_scl = 1'b1; clk_n(H);
    m_scl = 1'b0; clk_n(Q);
  endtask

  task automatic m_rbit(output logic b);
    m_sda = 1'b1; clk_n(Q);
    m_scl = 1'b1; clk_n(H / 2);
    b = sda_bus;  clk_n(H / 2);
    m_scl = 1'b0; clk_n(Q);
  endtask

  task automatic m_wbyte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) m_wbit(d[i]);
    m_rbit(b);
    ack = ~b;
  endtask

  task automatic m_rbyte(input logic ack, output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m_rbit(b);
      d = {d[6:0], b};
    end
    m_wbit(~ack);
  endtask

  // Set pointer, repeated START, read n (1..2) bytes, NACK the last, STOP.
  task automatic m_rd(input logic [7:0] p, input int n, output logic [7:0] b0, output logic [7:0] b1);
    logic a;
    b1 = 8'h00;
    m_start();
    m_wbyte(8'h78, a); chk("rd_addw_ack", 32'(a), 32'd1);
    m_wbyte(p, a);     chk("rd_ptr_ack", 32'(a), 32'd1);
    m_start();
    m_wbyte(8'h79, a); chk("rd_addr_ack", 32'(a), 32'd1);
    m_rbyte(n > 1, b0);
    if (n > 1) m_rbyte(1'b0, b1);
    chk("oe_after_nack", 32'(sda_oe), 32'd0);
    m_stop();
  endtask

  typedef struct {
    logic [7:0] addr_b;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    int         nd;
    logic       ack;
    int         nstb;
    logic [3:0] r0;
    logic [3:0] r1;
  } wvec_t;

  wvec_t tbl[4];

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish, required finish before 200000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    logic [7:0] b0, b1;
    logic bit0;

    tbl[0] = '{8'h78, 8'h02, 8'hA5, 8'h5A, 2, 1'b1, 2, 4'd2,  4'd3};
    tbl[1] = '{8'h7A, 8'h11, 8'h00, 8'h00, 0, 1'b0, 0, 4'd0,  4'd0};
    tbl[2] = '{8'h78, 8'h0F, 8'h11, 8'h22, 2, 1'b1, 2, 4'd15, 4'd0};
    tbl[3] = '{8'h78, 8'h37, 8'hC3, 8'h00, 1, 1'b1, 1, 4'd7,  4'd0};

    clk_n(5);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_wr_stb", 32'(wr_stb), 32'd0);
    chk("rst_wr_reg", 32'(wr_reg), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    clk_n(10);

    for (int i = 0; i < 4; i++) begin
      stbq.delete();
      oe_seen = 1'b0;
      busy_seen = 1'b0;
      m_start();
      m_wbyte(tbl[i].addr_b, a); chk($sformatf("v%0d_addr_ack", i), 32'(a), 32'(tbl[i].ack));
      m_wbyte(tbl[i].ptr, a);    chk($sformatf("v%0d_ptr_ack", i), 32'(a), 32'(tbl[i].ack));
      if (tbl[i].nd > 0) begin
        m_wbyte(tbl[i].d0, a);   chk($sformatf("v%0d_d0_ack", i), 32'(a), 32'(tbl[i].ack));
      end
      if (tbl[i].nd > 1) begin
        m_wbyte(tbl[i].d1, a);   chk($sformatf("v%0d_d1_ack", i), 32'(a), 32'(tbl[i].ack));
      end
      m_stop();
      chk($sformatf("v%0d_nstb", i), 32'(stbq.size()), 32'(tbl[i].nstb));
      if (tbl[i].nstb > 0 && stbq.size() > 0)
        chk($sformatf("v%0d_stb0", i), 32'(stbq[0]), 32'({tbl[i].r0, tbl[i].d0}));
      if (tbl[i].nstb > 1 && stbq.size() > 1)
        chk($sformatf("v%0d_stb1", i), 32'(stbq[1]), 32'({tbl[i].r1, tbl[i].d1}));
      chk($sformatf("v%0d_busy_seen", i), 32'(busy_seen), 32'(tbl[i].ack));
      if (!tbl[i].ack) chk($sformatf("v%0d_oe_seen", i), 32'(oe_seen), 32'd0);
    end

    m_rd(8'h02, 2, b0, b1);
    chk("rd02_b0", 32'(b0), 32'hA5);
    chk("rd02_b1", 32'(b1), 32'h5A);
    m_rd(8'h0F, 2, b0, b1);
    chk("rd0f_b0", 32'(b0), 32'h11);
    chk("rd0f_b1", 32'(b1), 32'h22);
    m_rd(8'h07, 1, b0, b1);
    chk("rd07_b0", 32'(b0), 32'hC3);

    // Abort by STOP four bits into a data byte.
    stbq.delete();
    m_start();
    m_wbyte(8'h78, a); chk("ab_addr_ack", 32'(a), 32'd1);
    m_wbyte(8'h05, a); chk("ab_ptr_ack", 32'(a), 32'd1);
    m_wbit(1'b1); m_wbit(1'b0); m_wbit(1'b1); m_wbit(1'b1);
    m_stop();
    chk("ab_nstb", 32'(stbq.size()), 32'd0);
    m_rd(8'h05, 1, b0, b1);
    chk("ab_rd05", 32'(b0), 32'h00);

    // Reset while the target drives bit 6 (0) of 0xA5.
    m_start();
    m_wbyte(8'h78, a); chk("mr_addw_ack", 32'(a), 32'd1);
    m_wbyte(8'h02, a); chk("mr_ptr_ack", 32'(a), 32'd1);
    m_start();
    m_wbyte(8'h79, a); chk("mr_addr_ack", 32'(a), 32'd1);
    m_rbit(bit0);
    chk("mr_bit7", 32'(bit0), 32'd1);
    chk("mr_oe_driving", 32'(sda_oe), 32'd1);
    rst = 1'b0;
    #1;
    chk("mr_oe_async", 32'(sda_oe), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_wr_reg", 32'(wr_reg), 32'd0);
    chk("mr_wr_data", 32'(wr_data), 32'd0);
    clk_n(3);
    m_sda = 1'b1; clk_n(Q);
    m_scl = 1'b1; clk_n(Q);
    rst = 1'b1;   clk_n(Q);
    m_rd(8'h02, 2, b0, b1);
    chk("mr_rd02_b0", 32'(b0), 32'h00);
    chk("mr_rd02_b1", 32'(b1), 32'h00);
    m_rd(8'h0F, 1, b0, b1);
    chk("mr_rd0f", 32'(b0), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
